// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: controller states,
// the hard-wired zero register and the default multiply/divide latency.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      INIT    = 2'b00,
      RUN     = 2'b01,
      MD_WAIT = 2'b10
   } ctrl_state_t;

   localparam logic [4:0] REG_ZERO        = 5'd0;
   localparam int         MDU_LAT_DEFAULT = 32;

   // Bits needed to hold MDU_LAT-1; a latency of 1 still needs one bit.
   function automatic int timer_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/md_timer.sv
// Down-counter that tracks how many busy cycles remain for the MULT/DIV unit.
// A load presets MDU_LAT-1; zero flags the final busy cycle.
module md_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int            W        = timer_width(MDU_LAT);
   localparam logic [W-1:0]  LOAD_VAL = W'(MDU_LAT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch-operand and
// imem-wait hazards, plus interlocking against the multi-cycle MULT/DIV unit.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_LAT = MDU_LAT_DEFAULT,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_branch,
   input  logic             id_branch_taken,
   input  logic             id_jump,
   input  logic             id_md_start,
   input  logic             id_md_read,
   input  logic             ex_regwrite,
   input  logic             ex_memtoreg,
   input  logic [4:0]       ex_rd,
   input  logic             imem_ready,
   output logic             pc_en,
   output logic             if2id_en,
   output logic             if2id_flush,
   output logic             id2ex_flush,
   output logic             md_go,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_count
);

   ctrl_state_t state;
   logic        active;
   logic        rs_hit;
   logic        rt_hit;
   logic        lu;
   logic        br;
   logic        md;
   logic        stall;
   logic        timer_zero;

   // Writes to $zero never create a dependency.
   assign rs_hit = (ex_rd != REG_ZERO) && (id_rs == ex_rd);
   assign rt_hit = (ex_rd != REG_ZERO) && (id_rt == ex_rd);

   assign active  = (state == RUN) || (state == MD_WAIT);
   assign lu      = ex_memtoreg && ((id_uses_rs && rs_hit) || (id_uses_rt && rt_hit));
   assign br      = id_branch && ex_regwrite && (rs_hit || rt_hit);
   assign md      = (state == MD_WAIT) && (id_md_start || id_md_read);
   assign stall   = active && (lu || br || md || !imem_ready);

   assign md_go   = (state == RUN) && id_md_start && !stall;
   assign md_busy = (state == MD_WAIT);

   always_comb begin
      pc_en       = 1'b0;
      if2id_en    = 1'b0;
      if2id_flush = 1'b0;
      id2ex_flush = 1'b0;
      if (!active) begin
         if2id_flush = 1'b1;
         id2ex_flush = 1'b1;
      end else if (stall) begin
         id2ex_flush = 1'b1;
      end else begin
         pc_en       = 1'b1;
         if2id_en    = 1'b1;
         if2id_flush = id_branch_taken || id_jump;
      end
   end

   md_timer #(
      .MDU_LAT (MDU_LAT)
   ) u_md_timer (
      .clk   (clk),
      .reset (reset),
      .load  (md_go),
      .dec   (md_busy),
      .zero  (timer_zero)
   );

   // Stall cycles are only counted once the pipeline is running.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= INIT;
         stall_count <= '0;
      end else begin
         case (state)
            INIT:    state <= RUN;
            RUN:     if (md_go) state <= MD_WAIT;
            MD_WAIT: if (timer_zero) state <= RUN;
            default: state <= INIT;
         endcase
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-level model of the hazard rules is
// compared against the DUT every cycle, plus hand-computed literal expectations.
module tb_pipe_hazard_ctrl;

   localparam int LAT = 4;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    id_rs;
   logic [4:0]    id_rt;
   logic          id_uses_rs;
   logic          id_uses_rt;
   logic          id_branch;
   logic          id_branch_taken;
   logic          id_jump;
   logic          id_md_start;
   logic          id_md_read;
   logic          ex_regwrite;
   logic          ex_memtoreg;
   logic [4:0]    ex_rd;
   logic          imem_ready;
   logic          pc_en;
   logic          if2id_en;
   logic          if2id_flush;
   logic          id2ex_flush;
   logic          md_go;
   logic          md_busy;
   logic [CW-1:0] stall_count;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rs;
      logic       uses_rt;
      logic       branch;
      logic       taken;
      logic       jump;
      logic       md_start;
      logic       md_read;
      logic       ex_regwrite;
      logic       ex_memtoreg;
      logic [4:0] ex_rd;
      logic       imem_ready;
   } stim_t;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   bit m_init = 1'b1;
   int m_busy = 0;
   int m_cnt  = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .MDU_LAT (LAT),
      .CNT_W   (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .id_branch       (id_branch),
      .id_branch_taken (id_branch_taken),
      .id_jump         (id_jump),
      .id_md_start     (id_md_start),
      .id_md_read      (id_md_read),
      .ex_regwrite     (ex_regwrite),
      .ex_memtoreg     (ex_memtoreg),
      .ex_rd           (ex_rd),
      .imem_ready      (imem_ready),
      .pc_en           (pc_en),
      .if2id_en        (if2id_en),
      .if2id_flush     (if2id_flush),
      .id2ex_flush     (id2ex_flush),
      .md_go           (md_go),
      .md_busy         (md_busy),
      .stall_count     (stall_count)
   );

   function automatic bit reg_hit(input logic [4:0] r);
      return (ex_rd != 5'd0) && (r == ex_rd);
   endfunction

   function automatic bit model_stall();
      bit load_use;
      bit branch_dep;
      bit md_dep;
      load_use   = ex_memtoreg && ((id_uses_rs && reg_hit(id_rs)) || (id_uses_rt && reg_hit(id_rt)));
      branch_dep = id_branch && ex_regwrite && (reg_hit(id_rs) || reg_hit(id_rt));
      md_dep     = (m_busy > 0) && (id_md_start || id_md_read);
      return !m_init && (load_use || branch_dep || md_dep || !imem_ready);
   endfunction

   // {pc_en, if2id_en, if2id_flush, id2ex_flush, md_go, md_busy}
   function automatic logic [5:0] model_outs();
      bit busy;
      busy = (m_busy > 0);
      if (m_init)
         return 6'b001100;
      else if (model_stall())
         return {4'b0001, 1'b0, busy};
      else
         return {1'b1, 1'b1, (id_branch_taken || id_jump), 1'b0,
                 (!busy && id_md_start), busy};
   endfunction

   // Model: m_busy counts remaining busy cycles of the multiply/divide unit.
   always @(posedge clk or posedge reset) begin : model_update
      bit st;
      bit go;
      if (reset) begin
         m_init = 1'b1;
         m_busy = 0;
         m_cnt  = 0;
      end else if (m_init) begin
         m_init = 1'b0;
      end else begin
         st = model_stall();
         go = (m_busy == 0) && id_md_start && !st;
         if (st && (m_cnt < (1 << CW) - 1)) m_cnt = m_cnt + 1;
         if (m_busy > 0) m_busy = m_busy - 1;
         if (go) m_busy = LAT;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         checks = checks + 1;
         if ({pc_en, if2id_en, if2id_flush, id2ex_flush, md_go, md_busy} !== model_outs()) begin
            failures = failures + 1;
            $display("[TB] FAIL model_outs t=%0t actual=%b expected=%b", $time,
                     {pc_en, if2id_en, if2id_flush, id2ex_flush, md_go, md_busy}, model_outs());
         end
         checks = checks + 1;
         if (stall_count !== CW'(m_cnt)) begin
            failures = failures + 1;
            $display("[TB] FAIL model_stall_count t=%0t actual=%0d expected=%0d", $time,
                     stall_count, m_cnt);
         end
      end
   end

   function automatic stim_t idle();
      stim_t s;
      s            = '0;
      s.imem_ready = 1'b1;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      id_rs           = s.rs;
      id_rt           = s.rt;
      id_uses_rs      = s.uses_rs;
      id_uses_rt      = s.uses_rt;
      id_branch       = s.branch;
      id_branch_taken = s.taken;
      id_jump         = s.jump;
      id_md_start     = s.md_start;
      id_md_read      = s.md_read;
      ex_regwrite     = s.ex_regwrite;
      ex_memtoreg     = s.ex_memtoreg;
      ex_rd           = s.ex_rd;
      imem_ready      = s.imem_ready;
   endtask

   task automatic applyStimulus(input stim_t s);
      @(posedge clk);
      #1;
      drive(s);
      @(negedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         failures = failures + 1;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   initial begin
      stim_t s;
      reset = 1'b1;
      drive(idle());
      @(posedge clk);
      cmp_en = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("init_pc_en", pc_en, 0);
      checkOutput("init_if2id_flush", if2id_flush, 1);
      checkOutput("init_id2ex_flush", id2ex_flush, 1);
      checkOutput("init_stall_count", stall_count, 0);

      applyStimulus(idle());
      checkOutput("run_pc_en", pc_en, 1);
      checkOutput("run_stall_count", stall_count, 0);

      s = idle(); s.ex_memtoreg = 1; s.ex_rd = 5'd8; s.rs = 5'd8; s.uses_rs = 1;
      applyStimulus(s);
      checkOutput("lu_pc_en", pc_en, 0);
      checkOutput("lu_if2id_en", if2id_en, 0);
      checkOutput("lu_id2ex_flush", id2ex_flush, 1);
      applyStimulus(idle());
      checkOutput("lu_after_pc_en", pc_en, 1);
      checkOutput("lu_stall_count", stall_count, 1);
      s.ex_rd = 5'd0; s.rs = 5'd0;
      applyStimulus(s);
      checkOutput("lu_zero_pc_en", pc_en, 1);
      checkOutput("lu_zero_id2ex_flush", id2ex_flush, 0);

      s = idle(); s.branch = 1; s.taken = 1; s.rs = 5'd3; s.rt = 5'd4;
      applyStimulus(s);
      checkOutput("br_flush", if2id_flush, 1);
      checkOutput("br_pc_en", pc_en, 1);
      s.ex_regwrite = 1; s.ex_rd = 5'd4;
      applyStimulus(s);
      checkOutput("br_dep_pc_en", pc_en, 0);
      checkOutput("br_dep_flush", if2id_flush, 0);
      s.ex_regwrite = 0;
      applyStimulus(s);
      checkOutput("br_late_flush", if2id_flush, 1);
      checkOutput("br_stall_count", stall_count, 2);

      s = idle(); s.md_start = 1;
      applyStimulus(s);
      checkOutput("mult_md_go", md_go, 1);
      checkOutput("mult_md_busy", md_busy, 0);
      s = idle(); s.md_read = 1;
      for (int i = 0; i < LAT; i++) begin
         applyStimulus(s);
         checkOutput("mflo_busy", md_busy, 1);
         checkOutput("mflo_pc_en", pc_en, 0);
      end
      applyStimulus(s);
      checkOutput("mflo_done_busy", md_busy, 0);
      checkOutput("mflo_done_pc_en", pc_en, 1);
      checkOutput("mflo_stall_count", stall_count, 6);

      s = idle(); s.jump = 1; s.imem_ready = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(s);
         checkOutput("imem_pc_en", pc_en, 0);
         checkOutput("imem_flush", if2id_flush, 0);
      end
      s.imem_ready = 1;
      applyStimulus(s);
      checkOutput("imem_late_flush", if2id_flush, 1);
      checkOutput("imem_stall_count", stall_count, 11);

      s = idle(); s.md_start = 1;
      applyStimulus(s);
      checkOutput("mult2_md_go", md_go, 1);
      applyStimulus(idle());
      checkOutput("unrelated_busy", md_busy, 1);
      checkOutput("unrelated_pc_en", pc_en, 1);

      @(posedge clk);
      #1 drive(s);
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_md_busy", md_busy, 0);
      checkOutput("rst_md_go", md_go, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("rst_init_pc_en", pc_en, 0);
      checkOutput("rst_init_md_go", md_go, 0);
      checkOutput("rst_init_id2ex_flush", id2ex_flush, 1);
      checkOutput("rst_stall_count", stall_count, 0);

      applyStimulus(idle());
      s = idle(); s.imem_ready = 0;
      for (int i = 0; i < 20; i++) applyStimulus(s);
      checkOutput("sat_stall_count", stall_count, 15);
      applyStimulus(idle());
      checkOutput("sat_hold_count", stall_count, 15);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
